// File: rtl/wbck_arb.sv
// Write-back arbiter: merges NCH result channels onto the single regfile
// write port through a registered commit stage, and raises the OITF clear
// for channels flagged as long-latency in LONG_MASK.
module wbck_arb #(
    parameter int unsigned     NCH        = 4,
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     RAW        = 5,
    parameter int unsigned     RR_MODE    = 0,
    parameter logic [NCH-1:0]  LONG_MASK  = 4'b0111,
    parameter int unsigned     STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      src_vld,
    output logic [NCH-1:0]      src_rdy,
    input  logic [NCH*XLEN-1:0] src_wdata,
    input  logic [NCH*RAW-1:0]  src_waddr,
    input  logic                wb_hold,
    output logic                reg_wen,
    output logic [RAW-1:0]      reg_waddr,
    output logic [XLEN-1:0]     reg_wdata,
    output logic                clr_req,
    output logic [RAW-1:0]      clr_idx
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic            out_vld;
    logic [RAW-1:0]  out_addr;
    logic [XLEN-1:0] out_data;
    logic            out_long;

    logic            advance;
    logic [NCH-1:0]  grant;
    logic [PW-1:0]   gidx;
    logic            any_grant;
    logic [NCH-1:0]  starved;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   wait_cnt [NCH];

    logic [XLEN-1:0] sel_data;
    logic [RAW-1:0]  sel_addr;
    logic            sel_long;

    assign advance   = ~out_vld | ~wb_hold;
    assign any_grant = |grant;
    assign src_rdy   = grant & {NCH{advance & ~rst}};

    // Channels whose wait counter has saturated get promoted over index order
    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            starved[i] = src_vld[i] && (STARVE_MAX != 0) && (wait_cnt[i] == CW'(STARVE_MAX));
        end
    end

    // Grant select: two passes give "preferred set first, then lowest valid";
    // in round-robin the preferred set is every channel at or after ptr
    always_comb begin
        grant = '0;
        gidx  = '0;
        if (RR_MODE != 0) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (grant == '0 && src_vld[i] && PW'(i) >= ptr) begin
                    grant[i] = 1'b1;
                    gidx     = PW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (grant == '0 && starved[i]) begin
                    grant[i] = 1'b1;
                    gidx     = PW'(i);
                end
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant == '0 && src_vld[i]) begin
                grant[i] = 1'b1;
                gidx     = PW'(i);
            end
        end
    end

    // Data/address/long-flag mux of the granted channel
    always_comb begin
        sel_data = '0;
        sel_addr = '0;
        sel_long = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_data = src_wdata[i*XLEN +: XLEN];
                sel_addr = src_waddr[i*RAW +: RAW];
                sel_long = LONG_MASK[i];
            end
        end
    end

    // Commit stage: loads the granted channel whenever it may advance
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            out_long <= 1'b0;
        end else if (advance) begin
            out_vld <= any_grant;
            if (any_grant) begin
                out_addr <= sel_addr;
                out_data <= sel_data;
                out_long <= sel_long;
            end
        end
    end

    // Round-robin pointer moves past the channel that transferred
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (RR_MODE != 0 && (|src_rdy)) begin
            ptr <= (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
        end
    end

    // Per-channel wait counters, saturating at STARVE_MAX
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rst || !src_vld[i] || src_rdy[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != CW'(STARVE_MAX)) begin
                wait_cnt[i] <= wait_cnt[i] + CW'(1);
            end
        end
    end

    assign reg_wen   = out_vld & ~wb_hold & (out_addr != '0);
    assign clr_req   = out_vld & ~wb_hold & out_long;
    assign reg_waddr = out_addr;
    assign clr_idx   = out_addr;
    assign reg_wdata = out_data;

endmodule
